// File: rtl/mine_placer.sv
// Mine map generator for the 8x8 board: clears the map, then places NUM_MINES mines
// at LFSR-chosen tiles, keeping the first-clicked tile (or its 3x3 block) clear.
// States: IDLE wait for start | CLEAR wipe map | PLACE try one candidate/cycle | DONE pulse done
module mine_placer #(
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  safe_tile,
  input  logic        safe_zone,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        busy,
  output logic        done,
  output logic [63:0] mine_map,
  output logic [6:0]  mine_count
);

  if (NUM_MINES < 1 || NUM_MINES > 55) begin : g_bad_num_mines
    $error("mine_placer: NUM_MINES must be in 1..55");
  end

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PLACE, S_DONE} state_e;

  localparam logic [6:0] LAST_COUNT = 7'(NUM_MINES - 1);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [63:0] map_q, map_d;
  logic [6:0]  count_q, count_d;
  logic [5:0]  safe_tile_q, safe_tile_d;
  logic        safe_zone_q, safe_zone_d;

  logic              lfsr_fb;
  logic [5:0]        cand;
  logic signed [3:0] d_row, d_col;
  logic              near, excluded, accept;

  // x^16+x^14+x^13+x^11+1, shift left; maximal length so the all-zero state never occurs
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  assign cand  = lfsr_q[5:0];
  assign d_row = $signed({1'b0, cand[5:3]}) - $signed({1'b0, safe_tile_q[5:3]});
  assign d_col = $signed({1'b0, cand[2:0]}) - $signed({1'b0, safe_tile_q[2:0]});
  assign near  = (d_row >= -4'sd1) && (d_row <= 4'sd1) &&
                 (d_col >= -4'sd1) && (d_col <= 4'sd1);
  assign excluded = safe_zone_q ? near : (cand == safe_tile_q);
  assign accept   = (state_q == S_PLACE) && !map_q[cand] && !excluded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_PLACE;
      S_PLACE: if (accept && count_q == LAST_COUNT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_CLEAR) || (state_q == S_PLACE);
    done       = (state_q == S_DONE);
    mine_map   = map_q;
    mine_count = count_q;
  end

  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_fb};
    map_d       = map_q;
    count_d     = count_q;
    safe_tile_d = safe_tile_q;
    safe_zone_d = safe_zone_q;
    if (state_q == S_IDLE && seed_load)
      lfsr_d = (seed == 16'd0) ? LFSR_SEED : seed;
    if (state_q == S_IDLE && start) begin
      safe_tile_d = safe_tile;
      safe_zone_d = safe_zone;
    end
    if (state_q == S_CLEAR) begin
      map_d   = 64'd0;
      count_d = 7'd0;
    end else if (accept) begin
      map_d   = map_q | (64'd1 << cand);
      count_d = count_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= LFSR_SEED;
      map_q       <= 64'd0;
      count_q     <= 7'd0;
      safe_tile_q <= 6'd0;
      safe_zone_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      map_q       <= map_d;
      count_q     <= count_d;
      safe_tile_q <= safe_tile_d;
      safe_zone_q <= safe_zone_d;
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: a 10-mine and a 55-mine instance, checked against
// a behavioural LFSR/placement model derived from the block description.
module tb_mine_placer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_s = 0, zone_s = 0, sl_s = 0;
  logic [5:0]  tile_s = 0;
  logic [15:0] seed_s = 0;
  logic        busy_s, done_s;
  logic [63:0] map_s;
  logic [6:0]  cnt_s;

  logic        start_b = 0, zone_b = 0, sl_b = 0;
  logic [5:0]  tile_b = 0;
  logic [15:0] seed_b = 0;
  logic        busy_b, done_b;
  logic [63:0] map_b;
  logic [6:0]  cnt_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mine_placer #(.NUM_MINES(10)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .safe_tile(tile_s), .safe_zone(zone_s),
    .seed_load(sl_s), .seed(seed_s), .busy(busy_s), .done(done_s),
    .mine_map(map_s), .mine_count(cnt_s));

  mine_placer #(.NUM_MINES(55)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .safe_tile(tile_b), .safe_zone(zone_b),
    .seed_load(sl_b), .seed(seed_b), .busy(busy_b), .done(done_b),
    .mine_map(map_b), .mine_count(cnt_b));

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit excl(input int c, input int s, input bit z);
    int dr, dc;
    dr = c / 8 - s / 8;
    dc = c % 8 - s % 8;
    if (!z) return c == s;
    return dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1;
  endfunction

  function automatic logic [63:0] excl_mask(input int s, input bit z);
    logic [63:0] m = '0;
    for (int i = 0; i < 64; i++) if (excl(i, s, z)) m[i] = 1'b1;
    return m;
  endfunction

  // init is the LFSR value right after the start edge; first candidate is one step later
  function automatic logic [63:0] model_map(input logic [15:0] init, input int tile,
                                            input bit zone, input int n);
    logic [15:0] l;
    logic [63:0] m;
    int k, guard, c;
    l = lstep(init);
    m = '0;
    k = 0;
    guard = 0;
    while (k < n && guard < 70000) begin
      c = int'(l[5:0]);
      if (!m[c] && !excl(c, tile, zone)) begin
        m[c] = 1'b1;
        k++;
      end
      l = lstep(l);
      guard++;
    end
    return m;
  endfunction

  function automatic logic [15:0] load_val(input logic [15:0] sd);
    return (sd == 16'd0) ? 16'hACE1 : sd;
  endfunction

  task automatic start_small(input logic [15:0] sd, input bit ld, input int tile, input bit zone);
    @(negedge clk);
    sl_s = ld; seed_s = sd; start_s = 1'b1; tile_s = 6'(tile); zone_s = zone;
    @(negedge clk);
    sl_s = 1'b0; start_s = 1'b0;
  endtask

  task automatic wait_small(input int budget, output bit seen);
    int n = 0;
    while (!done_s && n < budget) begin
      @(negedge clk);
      n++;
    end
    seen = done_s;
  endtask

  task automatic test_reset;
    bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_s, done_s, map_s, cnt_s} !== '0)
      $display("FAIL reset_hold: busy=%b done=%b map=%h cnt=%0d, want all 0", busy_s, done_s, map_s, cnt_s);
    else passed++;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({busy_s, done_s, map_s, cnt_s, busy_b, done_b, map_b, cnt_b} !== '0) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL idle_100: outputs left 0 while idle, last map=%h cnt=%0d", map_s, cnt_s);
    else passed++;
  endtask

  task automatic test_basic;
    bit seen;
    logic [63:0] exp, first;
    exp = model_map(16'h1234, 0, 1'b0, 10);
    for (int rep = 0; rep < 2; rep++) begin
      start_small(16'h1234, 1'b1, 0, 1'b0);
      checks++;
      if (busy_s !== 1'b1) $display("FAIL basic_busy_rise: busy=%b want 1", busy_s);
      else passed++;
      wait_small(2000, seen);
      checks++;
      if (!seen) $display("FAIL basic_done: done=%b want 1 within budget", done_s);
      else passed++;
      checks++;
      if (map_s !== exp) $display("FAIL basic_map: got %h want %h", map_s, exp);
      else passed++;
      checks++;
      if (cnt_s !== 7'd10 || $countones(map_s) != 10)
        $display("FAIL basic_count: cnt=%0d pop=%0d want 10", cnt_s, $countones(map_s));
      else passed++;
      checks++;
      if (map_s[0] !== 1'b0) $display("FAIL basic_safe_bit0: got %b want 0", map_s[0]);
      else passed++;
      checks++;
      if (busy_s !== 1'b0) $display("FAIL basic_busy_in_done: busy=%b want 0", busy_s);
      else passed++;
      @(negedge clk);
      checks++;
      if (done_s !== 1'b0 || map_s !== exp)
        $display("FAIL basic_single_pulse: done=%b map=%h want done 0 map held", done_s, map_s);
      else passed++;
      if (rep == 0) first = map_s;
      else begin
        checks++;
        if (map_s !== first) $display("FAIL basic_repeat: got %h want %h", map_s, first);
        else passed++;
      end
    end
  endtask

  task automatic test_zone_runs(input int tile, input int runs, input logic [15:0] base,
                                input logic [15:0] stride);
    bit seen;
    logic [15:0] sd;
    logic [63:0] exp, mask;
    mask = excl_mask(tile, 1'b1);
    for (int i = 0; i < runs; i++) begin
      sd = base + 16'(i) * stride;
      exp = model_map(load_val(sd), tile, 1'b1, 10);
      start_small(sd, 1'b1, tile, 1'b1);
      wait_small(2000, seen);
      checks++;
      if (!seen || map_s !== exp)
        $display("FAIL zone%0d_map seed=%h: done=%b got %h want %h", tile, sd, seen, map_s, exp);
      else passed++;
      checks++;
      if ((map_s & mask) !== 64'd0 || $countones(map_s) != 10)
        $display("FAIL zone%0d_clear seed=%h: excluded hits %h pop=%0d want 0/10", tile, sd,
                 map_s & mask, $countones(map_s));
      else passed++;
    end
  endtask

  task automatic test_zero_seed;
    bit seen;
    logic [63:0] exp;
    exp = model_map(16'hACE1, 45, 1'b0, 10);
    start_small(16'h0000, 1'b1, 45, 1'b0);
    wait_small(2000, seen);
    checks++;
    if (!seen || map_s !== exp || map_s[45] !== 1'b0)
      $display("FAIL zero_seed: done=%b got %h want %h", seen, map_s, exp);
    else passed++;
  endtask

  task automatic test_full_board;
    int n = 0;
    logic [63:0] mask;
    mask = excl_mask(27, 1'b1);
    @(negedge clk);
    sl_b = 1'b1; seed_b = 16'h5A5A; start_b = 1'b1; tile_b = 6'd27; zone_b = 1'b1;
    @(negedge clk);
    sl_b = 1'b0; start_b = 1'b0;
    while (!done_b && n < 70000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done_b) $display("FAIL full_done: done=%b want 1 within budget", done_b);
    else passed++;
    checks++;
    if (map_b !== ~mask || cnt_b !== 7'd55)
      $display("FAIL full_map: got %h cnt=%0d want %h cnt=55", map_b, cnt_b, ~mask);
    else passed++;
  endtask

  task automatic test_back_to_back;
    bit seen;
    logic [63:0] exp;
    exp = model_map(16'hBEEF, 12, 1'b1, 10);
    start_small(16'hBEEF, 1'b1, 12, 1'b1);
    start_s = 1'b1; sl_s = 1'b1; seed_s = 16'h1111; tile_s = 6'd40; zone_s = 1'b0;
    repeat (3) @(negedge clk);
    start_s = 1'b0; sl_s = 1'b0;
    wait_small(2000, seen);
    checks++;
    if (!seen || map_s !== exp)
      $display("FAIL busy_ignore: done=%b got %h want %h", seen, map_s, exp);
    else passed++;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_s !== 1'b0 || map_s !== exp)
      $display("FAIL done_start_ignored: busy=%b map=%h want busy 0 map held", busy_s, map_s);
    else passed++;
  endtask

  task automatic test_reset_mid_place;
    bit seen;
    int n = 0;
    logic [63:0] exp;
    start_small(16'h2468, 1'b1, 0, 1'b0);
    while (cnt_s < 7'd3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cnt_s < 7'd3 || busy_s !== 1'b1)
      $display("FAIL mid_progress: cnt=%0d busy=%b want >=3 and busy", cnt_s, busy_s);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_s, done_s, map_s, cnt_s} !== '0)
      $display("FAIL async_reset: busy=%b done=%b map=%h cnt=%0d want all 0", busy_s, done_s,
               map_s, cnt_s);
    else passed++;
    // start at the first edge after release: LFSR then holds step(reset value)
    exp = model_map(lstep(16'hACE1), 9, 1'b1, 10);
    @(negedge clk);
    rst_n = 1'b1; start_s = 1'b1; tile_s = 6'd9; zone_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    wait_small(2000, seen);
    checks++;
    if (!seen || map_s !== exp || $countones(map_s) != 10)
      $display("FAIL post_reset_run: done=%b got %h want %h", seen, map_s, exp);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zone_runs(27, 100, 16'h1000, 16'h0137);
    test_zone_runs(63, 10, 16'h7001, 16'h0A51);
    test_zone_runs(7, 20, 16'h3C00, 16'h0295);
    test_zero_seed;
    test_full_board;
    test_back_to_back;
    test_reset_mid_place;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
Name: mine_placer

Overview:
Generates the 64-bit mine map for the 8x8 board. The map is the input that the neighbor-count logic reads.
- On a start request, clears the map and places NUM_MINES mines at pseudo-random distinct tiles.
- Never places a mine on the player's first-clicked tile. Optionally also keeps its 3x3 neighbourhood clear.
- Sits between the game-control FSM, which issues start on the first click, and the board state / neighbor-count datapath.

Parameters:
NUM_MINES, 10, number of mines to place; legal range 1..55, checked at elaboration.
LFSR_SEED, 16'hACE1, LFSR reset value; also substituted when a zero seed is loaded.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to generate a new map; honoured only in IDLE
safe_tile  input  6  first-click tile index, row-major: row = idx/8, col = idx%8
safe_zone  input  1  1 = exclude the 3x3 block around safe_tile; 0 = exclude safe_tile only
seed_load  input  1  load seed into the LFSR; honoured only in IDLE
seed  input  16  seed value for seed_load
busy  output  1  high while generation is in progress
done  output  1  one-cycle pulse when the map is complete
mine_map  output  64  bit i = 1 means tile i is mined
mine_count  output  7  number of mines placed so far in the current generation

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state = IDLE, busy = 0, done = 0, mine_map = 0, mine_count = 0, LFSR = LFSR_SEED, latched safe tile/zone = 0. Reset asserted mid-generation aborts immediately to these values.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting left, feedback into bit 0.
  - Steps every clock in every state, so start timing adds entropy.
  - A zero state is never reachable.
- seed_load in IDLE: LFSR <= (seed == 0) ? LFSR_SEED : seed. seed_load has priority over the normal step that cycle. seed_load outside IDLE is ignored.
- IDLE, on start: latch safe_tile and safe_zone, go to CLEAR. busy rises the cycle after start.
- CLEAR (1 cycle): mine_map <= 0, mine_count <= 0, go to PLACE.
- PLACE, each cycle:
  - cand = LFSR[5:0].
  - Accept if mine_map[cand] == 0 and cand is not excluded. On accept: set mine_map[cand], mine_count += 1. At most one placement per cycle.
  - Exclusion when safe_zone = 1: |row(cand) - row(safe)| <= 1 and |col(cand) - col(safe)| <= 1, using signed or widened arithmetic. There is no wrap across row or board edges; tile 7 is not adjacent to tile 8.
  - Excluded zone size: corner 4, edge 6, interior 9 tiles.
  - Exclusion when safe_zone = 0: cand == safe.
  - When the count reaches NUM_MINES (the accept cycle that makes it so), go to DONE.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- Holding: mine_map and mine_count hold their values in IDLE until the next start's CLEAR.
- Termination: the LFSR low 6 bits take every value 0..63 within one LFSR period, so PLACE always terminates. No timeout logic.
- start while busy or in DONE: ignored, not queued.
- start and seed_load in the same IDLE cycle: both honoured. The seed loads and the transition to CLEAR happens.
- Determinism: the same seed loaded and the same number of cycles until start produce an identical mine_map.
- mine_map bits change only in CLEAR and on accepted placements. Consumers read mine_map after done.

Test Plan:
1. Reset then release, no start -> busy = 0, done = 0, mine_map = 0, mine_count = 0 for 100 cycles. Reset asserted async mid-cycle forces the same values without waiting for a clock edge.
2. NUM_MINES = 10, seed_load 16'h1234, start with safe_tile = 0, safe_zone = 0 -> exactly one done pulse; popcount(mine_map) = 10; mine_count = 10; bit 0 = 0. Repeating the identical sequence gives a bit-identical map.
3. safe_tile = 27, safe_zone = 1, 100 runs with varied seeds -> bits 18, 19, 20, 26, 27, 28, 34, 35, 36 are always 0; popcount = 10.
4. safe_tile = 63, safe_zone = 1 -> bits 54, 55, 62, 63 are always 0. safe_tile = 7, safe_zone = 1 -> bits 8 and 16 may be mined (no wrap); bits 6, 7, 14, 15 are always 0.
5. NUM_MINES = 55, safe_tile = 27, safe_zone = 1 -> done asserts; all 55 non-excluded tiles are mined.
6. Start pulsed again while busy, and seed_load while busy -> no restart and no LFSR disturbance versus the reference run. Reset during PLACE, then a new start -> a clean run with popcount = NUM_MINES.
